// File: rtl/mips_pkg_46.sv
// rtl/mips_pkg_46.sv - shared opcodes, control-bit indices and ID/EX entry type
package mips_pkg_46;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Bit positions inside ctrl: {reg_dst, alu_src, mem_rd, mem_wr, reg_wr, mem_to_reg, branch, jump}
    localparam int CTRL_REG_DST    = 7;
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_MEM_RD     = 5;
    localparam int CTRL_MEM_WR     = 4;
    localparam int CTRL_REG_WR     = 3;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_JUMP       = 0;

    localparam logic [7:0] CTRL_BUBBLE = 8'h00;

    typedef struct packed {
        logic          valid;
        logic          illegal;
        logic [7:0]    ctrl;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [DW-1:0] npc;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [5:0]    funct;
    } idex_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/writeback inputs and ID/EX outputs of the decode stage
interface decode_stage_if;
    import mips_pkg_46::*;

    logic [DW-1:0] IR_46;
    logic [DW-1:0] NPC_46;
    logic          flush_46;
    logic          wb_en_46;
    logic [AW-1:0] wb_addr_46;
    logic [DW-1:0] wb_data_46;

    logic          stall_46;
    logic [DW-1:0] A_46;
    logic [DW-1:0] B_46;
    logic [DW-1:0] Imm_46;
    logic [DW-1:0] NPC_o_46;
    logic [AW-1:0] rt_46;
    logic [AW-1:0] rd_46;
    logic [5:0]    funct_46;
    logic [7:0]    ctrl_46;
    logic          valid_46;
    logic          illegal_46;

    modport master (
        output IR_46, NPC_46, flush_46, wb_en_46, wb_addr_46, wb_data_46,
        input  stall_46, A_46, B_46, Imm_46, NPC_o_46, rt_46, rd_46, funct_46,
               ctrl_46, valid_46, illegal_46
    );

    modport slave (
        input  IR_46, NPC_46, flush_46, wb_en_46, wb_addr_46, wb_data_46,
        output stall_46, A_46, B_46, Imm_46, NPC_o_46, rt_46, rd_46, funct_46,
               ctrl_46, valid_46, illegal_46
    );

endinterface

// File: rtl/regfile_46.sv
// rtl/regfile_46.sv - 32x32 register file, two async read ports, write-through bypass
module regfile_46
    import mips_pkg_46::*;
(
    input  logic          clk_46,
    input  logic          rst_46,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];
    logic          wr_ok;

    // Next array contents: r0 is never written so it stays zero
    always_comb begin
        wr_ok = we && (wa != '0);
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wa] = wd;
        end
    end

    // Array storage with asynchronous clear
    always_ff @(posedge clk_46 or negedge rst_46) begin
        if (!rst_46) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads see a same-cycle writeback so decode never picks up a stale value
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) begin
            rd1 = (wr_ok && wa == ra1) ? wd : mem_q[ra1];
        end
        if (ra2 != '0) begin
            rd2 = (wr_ok && wa == ra2) ? wd : mem_q[ra2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS decode stage: control decode, load-use stall, ID/EX register
module decode_stage
    import mips_pkg_46::*;
(
    input  logic         clk_46,
    input  logic         rst_46,
    decode_stage_if.slave bus
);

    idex_t         idex_q;
    idex_t         idex_d;
    logic [5:0]    opcode;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [7:0]    ctrl_dec;
    logic          legal;
    logic          uses_rt;
    logic          load_use;
    logic          bubble;

    assign opcode = bus.IR_46[31:26];
    assign rs     = bus.IR_46[25:21];
    assign rt     = bus.IR_46[20:16];

    regfile_46 u_regfile (
        .clk_46 (clk_46),
        .rst_46 (rst_46),
        .ra1    (rs),
        .ra2    (rt),
        .rd1    (rs_val),
        .rd2    (rt_val),
        .we     (bus.wb_en_46),
        .wa     (bus.wb_addr_46),
        .wd     (bus.wb_data_46)
    );

    // Opcode to control bits; anything unrecognised is flagged illegal
    always_comb begin
        ctrl_dec = CTRL_BUBBLE;
        legal    = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                ctrl_dec[CTRL_REG_DST] = 1'b1;
                ctrl_dec[CTRL_REG_WR]  = 1'b1;
            end
            OP_ADDI: begin
                ctrl_dec[CTRL_ALU_SRC] = 1'b1;
                ctrl_dec[CTRL_REG_WR]  = 1'b1;
            end
            OP_LW: begin
                ctrl_dec[CTRL_ALU_SRC]    = 1'b1;
                ctrl_dec[CTRL_MEM_RD]     = 1'b1;
                ctrl_dec[CTRL_REG_WR]     = 1'b1;
                ctrl_dec[CTRL_MEM_TO_REG] = 1'b1;
            end
            OP_SW: begin
                ctrl_dec[CTRL_ALU_SRC] = 1'b1;
                ctrl_dec[CTRL_MEM_WR]  = 1'b1;
            end
            OP_BEQ:  ctrl_dec[CTRL_BRANCH] = 1'b1;
            OP_J:    ctrl_dec[CTRL_JUMP]   = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Hazard detection and next ID/EX entry; flush beats stall, non-valid entries hold zero data
    always_comb begin
        uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
        load_use = idex_q.valid && idex_q.ctrl[CTRL_MEM_RD] && (idex_q.rt != '0) &&
                   ((idex_q.rt == rs) || (uses_rt && idex_q.rt == rt));
        bubble   = bus.flush_46 || load_use;
        idex_d   = '0;
        if (!bubble) begin
            idex_d.illegal = !legal;
            if (legal) begin
                idex_d.valid = 1'b1;
                idex_d.ctrl  = ctrl_dec;
                idex_d.a     = rs_val;
                idex_d.b     = rt_val;
                idex_d.imm   = {{16{bus.IR_46[15]}}, bus.IR_46[15:0]};
                idex_d.npc   = bus.NPC_46;
                idex_d.rt    = rt;
                idex_d.rd    = bus.IR_46[15:11];
                idex_d.funct = bus.IR_46[5:0];
            end
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk_46 or negedge rst_46) begin
        if (!rst_46) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.stall_46   = load_use && !bus.flush_46;
    assign bus.A_46       = idex_q.a;
    assign bus.B_46       = idex_q.b;
    assign bus.Imm_46     = idex_q.imm;
    assign bus.NPC_o_46   = idex_q.npc;
    assign bus.rt_46      = idex_q.rt;
    assign bus.rd_46      = idex_q.rd;
    assign bus.funct_46   = idex_q.funct;
    assign bus.ctrl_46    = idex_q.ctrl;
    assign bus.valid_46   = idex_q.valid;
    assign bus.illegal_46 = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;

    decode_stage_if ifc ();

    decode_stage dut (
        .clk_46 (clk),
        .rst_46 (rst),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        stall;
        logic        valid;
        logic        illegal;
        logic [7:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rt;
    } vec_t;

    typedef struct {
        logic        stall;
        logic        valid;
        logic        illegal;
        logic [7:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
    } exp_t;

    // Reference state: architectural registers plus "a valid load is in ID/EX, targeting m_ld_rt"
    logic [31:0] m_regs [32];
    logic        m_ld_pending;
    logic [4:0]  m_ld_rt;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] dut_full();
        return {ifc.valid_46, ifc.illegal_46, ifc.ctrl_46, ifc.A_46, ifc.B_46, ifc.Imm_46,
                ifc.NPC_o_46, ifc.rt_46, ifc.rd_46, ifc.funct_46};
    endfunction

    function automatic logic [159:0] dut_part();
        return {ifc.valid_46, ifc.illegal_46, ifc.ctrl_46, ifc.A_46, ifc.B_46, ifc.Imm_46, ifc.rt_46};
    endfunction

    function automatic logic [159:0] exp_full(input exp_t e);
        return {e.valid, e.illegal, e.ctrl, e.a, e.b, e.imm, e.npc, e.rt, e.rd, e.funct};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (we && wa == r) return wd;
        return m_regs[r];
    endfunction

    function automatic exp_t model_step(input logic [31:0] ir, input logic [31:0] npc, input logic fl,
                                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t       e;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic [7:0] c;
        bit         known, reads_rt, hz;
        op = ir[31:26];
        rs = ir[25:21];
        rt = ir[20:16];
        known = 1;
        case (op)
            6'h00:   c = 8'b1000_1000;
            6'h08:   c = 8'b0100_1000;
            6'h23:   c = 8'b0110_1100;
            6'h2B:   c = 8'b0101_0000;
            6'h04:   c = 8'b0000_0010;
            6'h02:   c = 8'b0000_0001;
            default: begin c = 8'h00; known = 0; end
        endcase
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        hz = m_ld_pending && m_ld_rt != 0 && (rs == m_ld_rt || (reads_rt && rt == m_ld_rt));
        e = '{default: '0};
        e.stall = hz && !fl;
        if (!fl && !hz) begin
            e.illegal = !known;
            if (known) begin
                e.valid = 1;
                e.ctrl  = c;
                e.a     = m_read(rs, we, wa, wd);
                e.b     = m_read(rt, we, wa, wd);
                e.imm   = 32'(signed'(ir[15:0]));
                e.npc   = npc;
                e.rt    = rt;
                e.rd    = ir[15:11];
                e.funct = ir[5:0];
            end
        end
        m_ld_pending = e.valid && op == 6'h23;
        m_ld_rt      = rt;
        if (we && wa != 0) m_regs[wa] = wd;
        return e;
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [31:0] npc, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        ifc.IR_46      = ir;
        ifc.NPC_46     = npc;
        ifc.flush_46   = fl;
        ifc.wb_en_46   = we;
        ifc.wb_addr_46 = wa;
        ifc.wb_data_46 = wd;
    endtask

    // Called at posedge+1: drive, check stall mid-cycle, then check ID/EX after the edge
    task automatic apply_vec(input vec_t v, input string tag);
        drive(v.ir, v.npc, v.flush, v.wb_en, v.wb_addr, v.wb_data);
        #2;
        check({tag, " stall"}, 160'(ifc.stall_46), 160'(v.stall));
        @(posedge clk);
        #1;
        check({tag, " idex"}, dut_part(), {v.valid, v.illegal, v.ctrl, v.a, v.b, v.imm, v.rt});
    endtask

    vec_t tbl [12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        exp_t        e;
        logic [31:0] ir, npc, wd;
        logic        fl, we;
        logic [4:0]  wa;
        logic [5:0]  ops [7];

        tbl[0]  = '{32'h20090005, 32'h104, 0, 0, 5'd0, 32'h0,         0, 1, 0, 8'h48, 32'h0,        32'h0,        32'h5,        5'd9};
        tbl[1]  = '{32'h01295020, 32'h108, 0, 1, 5'd9, 32'hDEADBEEF,  0, 1, 0, 8'h88, 32'hDEADBEEF, 32'hDEADBEEF, 32'h5020,     5'd9};
        tbl[2]  = '{32'h8C090000, 32'h10C, 0, 0, 5'd0, 32'h0,         0, 1, 0, 8'h6C, 32'h0,        32'hDEADBEEF, 32'h0,        5'd9};
        tbl[3]  = '{32'h01295020, 32'h110, 0, 0, 5'd0, 32'h0,         1, 0, 0, 8'h00, 32'h0,        32'h0,        32'h0,        5'd0};
        tbl[4]  = '{32'h01295020, 32'h110, 0, 0, 5'd0, 32'h0,         0, 1, 0, 8'h88, 32'hDEADBEEF, 32'hDEADBEEF, 32'h5020,     5'd9};
        tbl[5]  = '{32'h20090005, 32'h114, 0, 1, 5'd0, 32'hFFFFFFFF,  0, 1, 0, 8'h48, 32'h0,        32'hDEADBEEF, 32'h5,        5'd9};
        tbl[6]  = '{32'h8C090000, 32'h118, 0, 0, 5'd0, 32'h0,         0, 1, 0, 8'h6C, 32'h0,        32'hDEADBEEF, 32'h0,        5'd9};
        tbl[7]  = '{32'h01295020, 32'h11C, 1, 0, 5'd0, 32'h0,         0, 0, 0, 8'h00, 32'h0,        32'h0,        32'h0,        5'd0};
        tbl[8]  = '{32'h01295020, 32'h120, 0, 0, 5'd0, 32'h0,         0, 1, 0, 8'h88, 32'hDEADBEEF, 32'hDEADBEEF, 32'h5020,     5'd9};
        tbl[9]  = '{32'hFC000000, 32'h124, 0, 0, 5'd0, 32'h0,         0, 0, 1, 8'h00, 32'h0,        32'h0,        32'h0,        5'd0};
        tbl[10] = '{32'h20090005, 32'h128, 0, 0, 5'd0, 32'h0,         0, 1, 0, 8'h48, 32'h0,        32'hDEADBEEF, 32'h5,        5'd9};
        tbl[11] = '{32'h2009FFFB, 32'h12C, 0, 0, 5'd0, 32'h0,         0, 1, 0, 8'h48, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFB, 5'd9};

        drive(32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
        #2;
        check("reset idex", dut_full(), 160'h0);
        check("reset stall", 160'(ifc.stall_46), 160'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset asserted in the middle of a load-use stall
        v = '{32'h8C090000, 32'h200, 0, 0, 5'd0, 32'h0, 0, 1, 0, 8'h6C, 32'h0, 32'hDEADBEEF, 32'h0, 5'd9};
        apply_vec(v, "midrst lw");
        drive(32'h01295020, 32'h204, 0, 0, 5'd0, 32'h0);
        #2;
        check("midrst stall before", 160'(ifc.stall_46), 160'h1);
        rst = 1'b0;
        #1;
        check("midrst idex", dut_full(), 160'h0);
        check("midrst stall after", 160'(ifc.stall_46), 160'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        v = '{32'h01295020, 32'h204, 0, 0, 5'd0, 32'h0, 0, 1, 0, 8'h88, 32'h0, 32'h0, 32'h5020, 5'd9};
        apply_vec(v, "postrst add");

        // Randomised run against the reference model
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_ld_pending = 0;
        m_ld_rt      = 0;
        ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23; ops[3] = 6'h2B;
        ops[4] = 6'h04; ops[5] = 6'h02; ops[6] = 6'h3F;
        ir = 32'h0;
        e  = '{default: '0};
        for (int n = 0; n < 400; n++) begin
            if (!e.stall) begin
                ir = $urandom;
                ir[31:26] = (n % 11 == 10) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
                ir[25:21] = 5'($urandom_range(0, 3));
                ir[20:16] = 5'($urandom_range(0, 3));
            end
            npc = $urandom;
            fl  = ($urandom_range(0, 7) == 0);
            we  = $urandom_range(0, 1) == 1;
            wa  = 5'($urandom_range(0, 3));
            wd  = $urandom;
            e = model_step(ir, npc, fl, we, wa, wd);
            drive(ir, npc, fl, we, wa, wd);
            #2;
            check($sformatf("rnd%0d stall", n), 160'(ifc.stall_46), 160'(e.stall));
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d idex", n), dut_full(), exp_full(e));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
